// File: rtl/rxll_fifo.sv
// rxll_fifo: SATA Rx link-layer FWFT frame buffer; in: ll2rxll_* dwords with sof/eof/err framing, rxdma2rxll_rd_en pop, port2rxll_ovf_clr; out: rxll2rxdma_rd_* 36-bit tagged head word/empty/eof_rdy, rxll2ll_hold, rxll2port_ovf, rxll2port_level
module rxll_fifo #(
  parameter int C_DEPTH_LOG2 = 9,
  parameter int C_HOLD_THRESH = 32
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [31:0]             ll2rxll_data,
  input  logic                    ll2rxll_valid,
  input  logic                    ll2rxll_sof,
  input  logic                    ll2rxll_eof,
  input  logic                    ll2rxll_err,
  output logic                    rxll2ll_hold,
  output logic [35:0]             rxll2rxdma_rd_do,
  output logic                    rxll2rxdma_rd_empty,
  input  logic                    rxdma2rxll_rd_en,
  output logic                    rxll2rxdma_rd_eof_rdy,
  output logic                    rxll2port_ovf,
  input  logic                    port2rxll_ovf_clr,
  output logic [C_DEPTH_LOG2:0]   rxll2port_level
);
  localparam int AW = C_DEPTH_LOG2;
  localparam int PW = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam logic [PW-1:0] FULL_X = {1'b1, {AW{1'b0}}};
  localparam logic [PW:0] DEPTH_W = (PW + 1)'(DEPTH);
  localparam logic [PW:0] THRESH_W = (PW + 1)'(C_HOLD_THRESH);

  typedef enum logic [1:0] {S_PASS, S_DISCARD, S_TERM} state_t;

  logic [35:0] mem [DEPTH];
  state_t state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fcnt_q, fcnt_d, level_q, level_d;
  logic [35:0] dout_q, dout_d, wr_word;
  logic vld_q, vld_d, hold_q, hold_d, ovf_q, ovf_d, dfis_q, dfis_d;
  logic pop, full, can_wr, wr_en, ovf_set, in_dfis;
  logic [PW:0] free;

  always_comb begin
    in_dfis = ll2rxll_sof ? (ll2rxll_data[7:0] == 8'h46) : dfis_q;
    pop = rxdma2rxll_rd_en & vld_q;
    full = (wr_ptr_q ^ rd_ptr_q) == FULL_X;
    can_wr = ~full | pop;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PASS:    state_d = (ll2rxll_valid & ~can_wr) ? (ll2rxll_eof ? S_TERM : S_DISCARD) : S_PASS;
      S_DISCARD: state_d = (ll2rxll_valid & ll2rxll_eof) ? S_TERM : S_DISCARD;
      default:   state_d = can_wr ? S_PASS : S_TERM;
    endcase
  end

  always_comb begin
    wr_en = (state_q == S_PASS) ? (ll2rxll_valid & can_wr) : ((state_q == S_TERM) & can_wr);
    ovf_set = (state_q == S_PASS) & ll2rxll_valid & ~can_wr;
    wr_word = (state_q == S_TERM) ? {2'b01, dfis_q, 1'b1, 32'h0}
                                  : {ll2rxll_sof, ll2rxll_eof, in_dfis, ll2rxll_eof & ll2rxll_err, ll2rxll_data};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    vld_d = rd_ptr_d != wr_ptr_q;
    dout_d = vld_d ? mem[rd_ptr_d[AW-1:0]] : dout_q;
    fcnt_d = fcnt_q + PW'(wr_en & wr_word[34]) - PW'(pop & dout_q[34]);
    level_d = wr_ptr_d - rd_ptr_d;
    free = DEPTH_W - {1'b0, level_d};
    hold_d = (free < THRESH_W) | (state_d != S_PASS);
    ovf_d = ovf_set | (ovf_q & ~port2rxll_ovf_clr);
    dfis_d = (ll2rxll_valid & ll2rxll_sof) ? (ll2rxll_data[7:0] == 8'h46) : dfis_q;
  end

  always_ff @(posedge sys_clk) if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_word;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= S_PASS;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q <= '0;
      level_q <= '0;
      dout_q <= '0;
      vld_q <= 1'b0;
      hold_q <= 1'b0;
      ovf_q <= 1'b0;
      dfis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q <= fcnt_d;
      level_q <= level_d;
      dout_q <= dout_d;
      vld_q <= vld_d;
      hold_q <= hold_d;
      ovf_q <= ovf_d;
      dfis_q <= dfis_d;
    end
  end

  assign rxll2ll_hold = hold_q;
  assign rxll2rxdma_rd_do = dout_q;
  assign rxll2rxdma_rd_empty = ~vld_q;
  assign rxll2rxdma_rd_eof_rdy = fcnt_q != '0;
  assign rxll2port_ovf = ovf_q;
  assign rxll2port_level = level_q;
endmodule

// File: tb/tb_rxll_fifo.sv
// tb_rxll_fifo: randomized scoreboard bench for rxll_fifo against a queue-based frame buffer model
module tb_rxll_fifo;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] data = '0;
  logic valid = 1'b0, sof = 1'b0, eof = 1'b0, err = 1'b0, rd_en = 1'b0, ovf_clr = 1'b0;
  logic hold, empty, eof_rdy, ovf;
  logic [35:0] rd_do;
  logic [9:0] level;

  rxll_fifo #(.C_DEPTH_LOG2(9), .C_HOLD_THRESH(32)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .ll2rxll_data(data), .ll2rxll_valid(valid), .ll2rxll_sof(sof), .ll2rxll_eof(eof), .ll2rxll_err(err),
    .rxll2ll_hold(hold), .rxll2rxdma_rd_do(rd_do), .rxll2rxdma_rd_empty(empty),
    .rxdma2rxll_rd_en(rd_en), .rxll2rxdma_rd_eof_rdy(eof_rdy),
    .rxll2port_ovf(ovf), .port2rxll_ovf_clr(ovf_clr), .rxll2port_level(level)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [35:0] q[$];
  int m_mode, m_fcnt, m_before;
  bit m_dfis, m_ovf, m_empty, m_hold, m_pop, m_acc, m_set;
  logic [35:0] m_w;

  // model: words stored = q; a word written at one edge is visible after the next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_mode = 0; m_fcnt = 0; m_dfis = 0; m_ovf = 0; m_empty = 1; m_hold = 0;
    end else begin
      chk("level", 36'(level), 36'(q.size()));
      chk("eof_rdy", 36'(eof_rdy), 36'(m_fcnt != 0));
      chk("empty", 36'(empty), 36'(m_empty));
      chk("hold", 36'(hold), 36'(m_hold));
      chk("ovf", 36'(ovf), 36'(m_ovf));
      m_pop = rd_en && !empty;
      m_before = q.size();
      if (m_pop) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL pop: word %h presented, scoreboard holds none", rd_do);
        end else begin
          chk("rd_do", rd_do, q[0]);
          if (q[0][34]) m_fcnt--;
          void'(q.pop_front());
        end
      end
      m_acc = (m_before < 512) || m_pop;
      m_set = 0;
      m_w = {sof, eof, sof ? (data[7:0] == 8'h46) : m_dfis, eof & err, data};
      if (m_mode == 0) begin
        if (valid) begin
          if (m_acc) begin
            q.push_back(m_w);
            if (eof) m_fcnt++;
          end else begin
            m_set = 1;
            m_mode = eof ? 2 : 1;
          end
        end
      end else if (m_mode == 1) begin
        if (valid && eof) m_mode = 2;
      end else if (m_acc) begin
        q.push_back({2'b01, m_dfis, 1'b1, 32'h0});
        m_fcnt++;
        m_mode = 0;
      end
      if (valid && sof) m_dfis = data[7:0] == 8'h46;
      m_empty = (m_before - int'(m_pop)) == 0;
      m_hold = (512 - q.size() < 32) || m_mode != 0;
      m_ovf = m_set || (m_ovf && !ovf_clr);
    end
  end

  task automatic drive(input logic v, input logic s, input logic e, input logic er, input logic [31:0] d, input logic re);
    valid = v; sof = s; eof = e; err = er; data = d; rd_en = re;
    @(posedge clk); #1;
    valid = 0; sof = 0; eof = 0; err = 0; rd_en = 0; ovf_clr = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic drain(input string name, input int budget);
    idle(2);
    for (int k = 0; k < budget && !empty; k++) drive(0, 0, 0, 0, 32'h0, 1);
    idle(1);
    chk({name, "_empty"}, 36'(empty), 36'(1));
    chk({name, "_eof_rdy"}, 36'(eof_rdy), 36'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int len, tot;
  bit sent, v;
  logic [31:0] d;

  initial begin
    idle(3);
    rst_n = 1;
    idle(1);
    chk("rst_do", rd_do, 36'h0);
    chk("rst_empty", 36'(empty), 36'(1));
    chk("rst_level", 36'(level), 36'(0));

    drive(1, 1, 0, 0, 32'h00000046, 0);
    drive(1, 0, 0, 0, 32'hA5A5A5A5, 0);
    drive(1, 0, 1, 0, 32'h12345678, 0);
    idle(1);
    chk("sf_tag0", 36'(rd_do[35:32]), 36'(4'hA));
    chk("sf_rdy0", 36'(eof_rdy), 36'(1));
    drive(0, 0, 0, 0, 32'h0, 1);
    chk("sf_tag1", 36'(rd_do[35:32]), 36'(4'h2));
    chk("sf_rdy1", 36'(eof_rdy), 36'(1));
    drive(0, 0, 0, 0, 32'h0, 1);
    chk("sf_tag2", 36'(rd_do[35:32]), 36'(4'h6));
    chk("sf_rdy2", 36'(eof_rdy), 36'(1));
    drive(0, 0, 0, 0, 32'h0, 1);
    chk("sf_empty", 36'(empty), 36'(1));
    chk("sf_rdy3", 36'(eof_rdy), 36'(0));

    drive(1, 1, 1, 1, 32'h00000034, 0);
    idle(1);
    chk("one_dw", rd_do, {4'hD, 32'h34});
    chk("one_rdy", 36'(eof_rdy), 36'(1));
    drive(1, 1, 1, 0, 32'h00000027, 1);
    chk("pp_level", 36'(level), 36'(1));
    chk("pp_rdy", 36'(eof_rdy), 36'(1));
    idle(1);
    chk("pp_word", rd_do, {4'hC, 32'h27});
    drain("pp", 10);

    for (int i = 0; i < 481; i++) begin
      drive(1, i == 0, 0, 0, 32'(i), 0);
      if (i == 479) chk("hold_480", 36'(hold), 36'(0));
    end
    chk("hold_481", 36'(hold), 36'(1));
    drive(0, 0, 0, 0, 32'h0, 1);
    drive(0, 0, 0, 0, 32'h0, 1);
    chk("hold_drain", 36'(hold), 36'(0));
    for (int i = 0; i < 33; i++) drive(1, 0, 0, 0, 32'(1000 + i), 0);
    chk("full_level", 36'(level), 36'(512));
    for (int i = 0; i < 4; i++) drive(1, 0, i == 3, 0, 32'(2000 + i), 0);
    chk("ovf_set", 36'(ovf), 36'(1));
    chk("ovf_level", 36'(level), 36'(512));
    chk("ovf_nordy", 36'(eof_rdy), 36'(0));
    idle(2);
    drive(0, 0, 0, 0, 32'h0, 1);
    chk("term_rdy", 36'(eof_rdy), 36'(1));
    chk("term_level", 36'(level), 36'(512));
    ovf_clr = 1;
    drive(0, 0, 0, 0, 32'h0, 0);
    chk("ovf_clr", 36'(ovf), 36'(0));
    for (int k = 0; k < 600 && !empty; k++) begin
      if (rd_do[34]) chk("synth_eof", rd_do, {4'h5, 32'h0});
      drive(0, 0, 0, 0, 32'h0, 1);
    end
    drain("ovf", 10);

    drive(1, 1, 0, 0, 32'h00000046, 0);
    drive(1, 0, 1, 0, 32'h11111111, 0);
    drive(1, 1, 0, 0, 32'h00000046, 0);
    rst_n = 0;
    idle(1);
    rst_n = 1;
    idle(2);
    chk("mrst_empty", 36'(empty), 36'(1));
    chk("mrst_level", 36'(level), 36'(0));
    chk("mrst_rdy", 36'(eof_rdy), 36'(0));

    tot = 0;
    for (int f = 0; f < 10; f++) begin
      len = (f < 9) ? 140 + int'($urandom_range(0, 20)) : 1500 - tot;
      tot += len;
      for (int w = 0; w < len; w++) begin
        d = $urandom;
        if (w == 0) d[7:0] = (f % 2 == 1) ? 8'h46 : 8'h39;
        sent = 0;
        for (int t = 0; t < 200 && !sent; t++) begin
          v = !hold && ($urandom_range(0, 3) != 0);
          drive(v, w == 0, w == len - 1, (w == len - 1) ? 1'($urandom_range(0, 1)) : 1'b0, d, 1'($urandom_range(0, 1)));
          sent = v;
        end
        if (!sent) begin
          n_chk++; n_fail++;
          $display("FAIL wrap_send: word %0d of frame %0d not sent, hold stuck", w, f);
        end
      end
    end
    drain("wrap", 2000);
    chk("wrap_ovf", 36'(ovf), 36'(0));
    chk("wrap_sb", 36'(q.size()), 36'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
